i2so_sample_fifo: RTL and testbench



---
 rtl/i2so_sample_fifo.sv | 119 +++++++++++
 tb/tb_i2so_sample_fifo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2so_sample_fifo.sv
// Stereo sample FIFO that feeds the I2S output serializer.
// Pairs enter on a valid/ready handshake and leave one per rtr strobe; underflow is counted.
module i2so_sample_fifo #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter bit HOLD_LAST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [15:0]   wr_lft,
    input  logic [15:0]   wr_rgt,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          rtr,
    output logic [15:0]   i2so_lft,
    output logic [15:0]   i2so_rgt,
    output logic [AW:0]   fifo_level,
    output logic          underflow,
    output logic [7:0]    underflow_cnt
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [15:0]   lft_q, lft_d;
    logic [15:0]   rgt_q, rgt_d;
    logic          uf_q, uf_d;
    logic [7:0]    ucnt_q, ucnt_d;
    logic          wr_en;
    logic          pop;
    logic          starve;

    assign wr_ready = (level_q != FULL_LEVEL);

    always_comb begin
        wr_en    = wr_valid && wr_ready && !clr;
        pop      = rtr && (level_q != '0) && !clr;
        starve   = rtr && (level_q == '0) && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        lft_d    = lft_q;
        rgt_d    = rgt_q;
        uf_d     = uf_q;
        ucnt_d   = ucnt_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            lft_d    = '0;
            rgt_d    = '0;
            uf_d     = 1'b0;
            ucnt_d   = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                lft_d    = mem_q[rd_ptr_q][31:16];
                rgt_d    = mem_q[rd_ptr_q][15:0];
            end
            // A write landing in an empty FIFO is never bypassed to the outputs.
            if (starve) begin
                uf_d = 1'b1;
                if (ucnt_q != 8'hFF) begin
                    ucnt_d = ucnt_q + 1'b1;
                end
                if (!HOLD_LAST) begin
                    lft_d = '0;
                    rgt_d = '0;
                end
            end
            unique case ({wr_en, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {wr_lft, wr_rgt};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            lft_q    <= '0;
            rgt_q    <= '0;
            uf_q     <= 1'b0;
            ucnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            lft_q    <= lft_d;
            rgt_q    <= rgt_d;
            uf_q     <= uf_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign i2so_lft      = lft_q;
    assign i2so_rgt      = rgt_q;
    assign fifo_level    = level_q;
    assign underflow     = uf_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_i2so_sample_fifo.sv
// Self-checking bench for i2so_sample_fifo: directed vector table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_i2so_sample_fifo;

    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam bit HOLD_LAST = 1'b1;

    logic          clk;
    logic          rst;
    logic          clr;
    logic [15:0]   wr_lft;
    logic [15:0]   wr_rgt;
    logic          wr_valid;
    logic          wr_ready;
    logic          rtr;
    logic [15:0]   i2so_lft;
    logic [15:0]   i2so_rgt;
    logic [AW:0]   fifo_level;
    logic          underflow;
    logic [7:0]    underflow_cnt;

    i2so_sample_fifo #(.DEPTH(DEPTH), .AW(AW), .HOLD_LAST(HOLD_LAST)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_lft(wr_lft), .wr_rgt(wr_rgt), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rtr(rtr), .i2so_lft(i2so_lft), .i2so_rgt(i2so_rgt),
        .fifo_level(fifo_level), .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of {lft,rgt} pairs plus the visible output state.
    logic [31:0] mq[$];
    logic [15:0] m_lft, m_rgt;
    logic        m_uf;
    int          m_cnt;

    typedef struct {
        logic        wv;
        logic [15:0] l;
        logic [15:0] r;
        logic        rd;
        logic        cl;
        logic [15:0] e_l;
        logic [15:0] e_r;
        int          e_lvl;
        logic        e_uf;
        int          e_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_lft = '0;
        m_rgt = '0;
        m_uf  = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic wv, input logic [15:0] l, input logic [15:0] r,
                              input logic rd, input logic cl);
        bit accept;
        if (cl) begin
            model_reset();
        end else begin
            accept = wv && (mq.size() < DEPTH);
            if (rd) begin
                if (mq.size() > 0) begin
                    {m_lft, m_rgt} = mq.pop_front();
                end else begin
                    m_uf = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (!HOLD_LAST) begin
                        m_lft = '0;
                        m_rgt = '0;
                    end
                end
            end
            if (accept) mq.push_back({l, r});
        end
    endtask

    task automatic drive(input logic wv, input logic [15:0] l, input logic [15:0] r,
                         input logic rd, input logic cl);
        wr_valid = wv;
        wr_lft   = l;
        wr_rgt   = r;
        rtr      = rd;
        clr      = cl;
        model_step(wv, l, r, rd, cl);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rtr      = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".lft"},   32'(i2so_lft),      32'(m_lft));
        chk({tag, ".rgt"},   32'(i2so_rgt),      32'(m_rgt));
        chk({tag, ".level"}, 32'(fifo_level),    32'(mq.size()));
        chk({tag, ".uf"},    32'(underflow),     32'(m_uf));
        chk({tag, ".cnt"},   32'(underflow_cnt), 32'(m_cnt));
        chk({tag, ".ready"}, 32'(wr_ready),      32'(mq.size() != DEPTH));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; rtr = 1'b0;
        wr_lft = '0; wr_rgt = '0;
        model_reset();

        //               wv  l         r         rd cl  e_l       e_r       lvl uf cnt
        vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 0};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 1};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 2};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b1, 3};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 0};
        vecs[5] = '{1'b1, 16'h1111, 16'hAAAA, 1'b0, 1'b0, 16'h0000, 16'h0000, 1, 1'b0, 0};
        vecs[6] = '{1'b1, 16'h2222, 16'hBBBB, 1'b0, 1'b0, 16'h0000, 16'h0000, 2, 1'b0, 0};
        vecs[7] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111, 16'hAAAA, 1, 1'b0, 0};
        vecs[8] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h2222, 16'hBBBB, 0, 1'b0, 0};
        vecs[9] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h2222, 16'hBBBB, 0, 1'b1, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.lft",   32'(i2so_lft),      32'h0);
        chk("reset.rgt",   32'(i2so_rgt),      32'h0);
        chk("reset.level", 32'(fifo_level),    32'h0);
        chk("reset.uf",    32'(underflow),     32'h0);
        chk("reset.cnt",   32'(underflow_cnt), 32'h0);
        rst = 1'b0;
        #1;
        chk("reset.ready", 32'(wr_ready), 32'h1);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].wv, vecs[i].l, vecs[i].r, vecs[i].rd, vecs[i].cl);
            chk($sformatf("vec%0d.lft", i),   32'(i2so_lft),      32'(vecs[i].e_l));
            chk($sformatf("vec%0d.rgt", i),   32'(i2so_rgt),      32'(vecs[i].e_r));
            chk($sformatf("vec%0d.level", i), 32'(fifo_level),    32'(vecs[i].e_lvl));
            chk($sformatf("vec%0d.uf", i),    32'(underflow),     32'(vecs[i].e_uf));
            chk($sformatf("vec%0d.cnt", i),   32'(underflow_cnt), 32'(vecs[i].e_cnt));
        end

        // Fill past full with distinct pairs, then write+rtr at full, then drain.
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'(16'h0100 + i), 16'(16'hF000 + i), 1'b0, 1'b0);
            chk($sformatf("fill%0d.level", i), 32'(fifo_level), 32'((i + 1 > DEPTH) ? DEPTH : i + 1));
            compare_model($sformatf("fill%0d", i));
        end
        chk("full.ready", 32'(wr_ready), 32'h0);
        drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
        chk("fullwr.level", 32'(fifo_level), 32'd7);
        chk("fullwr.lft",   32'(i2so_lft),   32'h0100);
        compare_model("fullwr");
        for (int i = 1; i < DEPTH; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            chk($sformatf("drain%0d.lft", i), 32'(i2so_lft), 32'(16'h0100 + i));
            chk($sformatf("drain%0d.rgt", i), 32'(i2so_rgt), 32'(16'hF000 + i));
            compare_model($sformatf("drain%0d", i));
        end

        // Simultaneous write and pop at level 3 (pointers have wrapped by now).
        for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h3000 + i), 16'(16'h4000 + i), 1'b0, 1'b0);
        drive(1'b1, 16'h3003, 16'h4003, 1'b1, 1'b0);
        chk("lvl3.level", 32'(fifo_level), 32'd3);
        chk("lvl3.lft",   32'(i2so_lft),   32'h3000);
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
            compare_model($sformatf("lvl3pop%0d", i));
        end

        // Saturate the underflow counter, then clr with a competing write and rtr.
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("sat.cnt", 32'(underflow_cnt), 32'd255);
        compare_model("sat");
        drive(1'b1, 16'h5555, 16'h6666, 1'b1, 1'b1);
        chk("clr.level", 32'(fifo_level),    32'h0);
        chk("clr.uf",    32'(underflow),     32'h0);
        chk("clr.cnt",   32'(underflow_cnt), 32'h0);
        chk("clr.lft",   32'(i2so_lft),      32'h0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("clrnowr.level", 32'(fifo_level),    32'h0);
        chk("clrnowr.cnt",   32'(underflow_cnt), 32'h1);
        chk("clrnowr.lft",   32'(i2so_lft),      32'h0);

        // Asynchronous reset in the middle of a clock phase with data buffered.
        for (int i = 0; i < 5; i++) drive(1'b1, 16'(16'h7000 + i), 16'(16'h8000 + i), 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        compare_model("prerst");
        #2;
        rst = 1'b1;
        #1;
        chk("arst.lft",   32'(i2so_lft),      32'h0);
        chk("arst.rgt",   32'(i2so_rgt),      32'h0);
        chk("arst.level", 32'(fifo_level),    32'h0);
        chk("arst.uf",    32'(underflow),     32'h0);
        chk("arst.cnt",   32'(underflow_cnt), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 16'h9ABC, 16'hCDEF, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        chk("postrst.lft", 32'(i2so_lft), 32'h9ABC);
        chk("postrst.rgt", 32'(i2so_rgt), 32'hCDEF);
        compare_model("postrst");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 99) < 55), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2));
            compare_model($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
